// File: rtl/demux_buffered.sv
// Registered 1-to-CHANNELS demultiplexer. Each channel has a one-word holding register.
// Every channel drains through its own valid/ready port, independently of the others.
module demux_buffered #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int SEL_W    = 1,
  parameter int CNT_W    = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          in_select,
  input  logic [WIDTH-1:0]          in_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      drop_err,
  output logic [CNT_W-1:0]          accept_count
);

  localparam int unsigned LP_CH = CHANNELS;

  logic [CHANNELS-1:0] w_full;
  logic                w_sel_ok;
  logic                w_full_sel;
  logic                w_rdy_sel;
  logic                w_accept;
  logic                w_route;
  logic                w_drop;
  logic                r_drop_err;
  logic [CNT_W-1:0]    r_count;

  // A selected channel can take a word when it is empty or is being drained this cycle.
  always_comb begin
    w_sel_ok   = (32'(in_select) < LP_CH);
    w_full_sel = 1'b0;
    w_rdy_sel  = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (32'(in_select) == 32'(k)) begin
        w_full_sel = w_full[k];
        w_rdy_sel  = out_ready[k];
      end
    end
    in_ready = w_sel_ok ? (!w_full_sel || w_rdy_sel) : 1'b1;
  end

  assign w_accept = in_valid & in_ready;
  assign w_route  = w_accept & w_sel_ok;
  assign w_drop   = w_accept & ~w_sel_ok;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic             r_full;
    logic [WIDTH-1:0] r_data;
    logic             w_hit;

    assign w_hit = w_route & (32'(in_select) == 32'(k));

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_full <= 1'b0;
        r_data <= '0;
      end else if (w_hit) begin
        r_full <= 1'b1;
        r_data <= in_data;
      end else if (r_full && out_ready[k]) begin
        r_full <= 1'b0;
      end
    end

    assign w_full[k]                    = r_full;
    assign out_valid[k]                 = r_full;
    assign out_data[k*WIDTH +: WIDTH]   = r_data;
  end

  // Dropped words are consumed silently except for the sticky error flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_err <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_drop)  r_drop_err <= 1'b1;
      if (w_route) r_count    <= r_count + CNT_W'(1);
    end
  end

  assign drop_err     = r_drop_err;
  assign accept_count = r_count;

endmodule

// File: tb/tb_demux_buffered.sv
// Scoreboard bench for demux_buffered in a 3-channel, 2-bit-select, 4-bit-counter build.
// Per-channel queues model the holding registers; a negedge monitor checks the DUT against them.
module tb_demux_buffered;

  localparam int W  = 4;
  localparam int CH = 3;
  localparam int SW = 2;
  localparam int CW = 4;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [SW-1:0]     in_select;
  logic [W-1:0]      in_data;
  logic [CH-1:0]     out_valid;
  logic [CH-1:0]     out_ready;
  logic [CH*W-1:0]   out_data;
  logic              drop_err;
  logic [CW-1:0]     accept_count;

  demux_buffered #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_select(in_select), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .drop_err(drop_err),
    .accept_count(accept_count)
  );

  always #5 clock = ~clock;

  logic [W-1:0] q [CH][$];
  int           exp_cnt;
  bit           exp_drop;
  int           total;
  int           bad;
  bit           last_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT against model state, then retire drained words.
  always @(negedge clock) begin
    logic [CH-1:0] ev;
    logic          er;
    if (reset_n) begin
      for (int k = 0; k < CH; k++) ev[k] = (q[k].size() != 0);
      chk("out_valid", 32'(out_valid), 32'(ev));
      for (int k = 0; k < CH; k++)
        if (ev[k]) chk("out_data", 32'(out_data[k*W +: W]), 32'(q[k][0]));
      if (int'(in_select) >= CH) er = 1'b1;
      else er = (q[in_select].size() == 0) || out_ready[in_select];
      chk("in_ready", 32'(in_ready), 32'(er));
      chk("drop_err", 32'(drop_err), 32'(exp_drop));
      chk("accept_count", 32'(accept_count), exp_cnt % 16);
      for (int k = 0; k < CH; k++)
        if (ev[k] && out_ready[k]) void'(q[k].pop_front());
    end
  end

  // Called at posedge+1; drives one cycle, records any accept, returns at next posedge+1.
  task automatic cycle(input bit v, input int sel, input logic [W-1:0] d, input logic [CH-1:0] ordy);
    in_valid  = v;
    in_select = SW'(sel);
    in_data   = d;
    out_ready = ordy;
    @(negedge clock);
    #1;
    last_rdy = in_ready;
    if (in_valid && in_ready) begin
      if (sel < CH) begin
        q[sel].push_back(d);
        exp_cnt++;
      end else begin
        exp_drop = 1'b1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    for (int k = 0; k < CH; k++) q[k].delete();
    exp_cnt  = 0;
    exp_drop = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; last_rdy = 1'b0;
    clear_model();
    reset_n = 1'b0; in_valid = 1'b0; in_select = '0; in_data = '0; out_ready = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_drop_err", 32'(drop_err), 0);
    chk("rst_count", 32'(accept_count), 0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;

    // Routing
    cycle(1, 0, 4'hA, 3'b000);
    chk("route_valid", 32'(out_valid), 32'b001);
    chk("route_data0", 32'(out_data[3:0]), 32'hA);
    chk("route_ch1", 32'(out_data[7:4]), 0);
    chk("route_count", 32'(accept_count), 1);

    // Backpressure
    cycle(1, 0, 4'h5, 3'b000);
    chk("bp_ready", 32'(last_rdy), 0);
    chk("bp_hold", 32'(out_data[3:0]), 32'hA);
    cycle(1, 1, 4'h5, 3'b000);
    chk("bp_other_ready", 32'(last_rdy), 1);
    chk("bp_valid", 32'(out_valid), 32'b011);

    // Streaming through a full channel
    for (int i = 3; i <= 6; i++) begin
      cycle(1, 0, W'(i), 3'b001);
      chk("stream_ready", 32'(last_rdy), 1);
      chk("stream_data", 32'(out_data[3:0]), i);
    end
    chk("stream_ch1_hold", 32'(out_data[7:4]), 32'h5);
    cycle(0, 0, 4'h0, 3'b011);
    chk("drained", 32'(out_valid), 0);

    // Out-of-range select
    cycle(1, 3, 4'hF, 3'b000);
    chk("drop_ready", 32'(last_rdy), 1);
    chk("drop_valid", 32'(out_valid), 0);
    chk("drop_flag", 32'(drop_err), 1);
    chk("drop_count", 32'(accept_count), 6);
    cycle(1, 2, 4'h7, 3'b000);
    chk("after_drop_valid", 32'(out_valid), 32'b100);
    chk("after_drop_data", 32'(out_data[11:8]), 32'h7);
    chk("after_drop_flag", 32'(drop_err), 1);
    chk("after_drop_count", 32'(accept_count), 7);

    // Asynchronous reset in the middle of a cycle
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 0);
    chk("async_out_data", 32'(out_data), 0);
    chk("async_drop_err", 32'(drop_err), 0);
    chk("async_count", 32'(accept_count), 0);
    clear_model();
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;

    // Counter wrap: 17 routed words
    for (int i = 0; i < 17; i++) cycle(1, $urandom_range(2, 0), W'($urandom), 3'b111);
    chk("wrap_count", 32'(accept_count), 1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom), $urandom_range(3, 0), W'($urandom), CH'($urandom));
    for (int i = 0; i < 3; i++) cycle(0, 0, 4'h0, 3'b111);
    chk("final_queues", 32'(q[0].size() + q[1].size() + q[2].size()), 0);
    chk("final_valid", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
